// File: rtl/router_switch_if.sv
// router_switch_if: five-port link bundle of the XY mesh router.
// Carries input FIFO heads and pops, output links and downstream occupancy.
interface router_switch_if #(
    parameter int DATASIZE = 40,
    parameter int WIDTH = 3
);
    logic [DATASIZE-1:0] N_data_in, E_data_in, S_data_in, W_data_in, L_data_in;
    logic N_valid_in, E_valid_in, S_valid_in, W_valid_in, L_valid_in;
    logic fifo_ready_N, fifo_ready_E, fifo_ready_S, fifo_ready_W, fifo_ready_L;
    logic [DATASIZE-1:0] N_data_out, E_data_out, S_data_out, W_data_out, L_data_out;
    logic N_valid_out, E_valid_out, S_valid_out, W_valid_out, L_valid_out;
    logic [WIDTH:0] N_pressure_in, E_pressure_in, S_pressure_in, W_pressure_in, L_pressure_in;

    modport master (
        output N_data_in, E_data_in, S_data_in, W_data_in, L_data_in,
        output N_valid_in, E_valid_in, S_valid_in, W_valid_in, L_valid_in,
        input  fifo_ready_N, fifo_ready_E, fifo_ready_S, fifo_ready_W, fifo_ready_L,
        input  N_data_out, E_data_out, S_data_out, W_data_out, L_data_out,
        input  N_valid_out, E_valid_out, S_valid_out, W_valid_out, L_valid_out,
        output N_pressure_in, E_pressure_in, S_pressure_in, W_pressure_in, L_pressure_in
    );

    modport slave (
        input  N_data_in, E_data_in, S_data_in, W_data_in, L_data_in,
        input  N_valid_in, E_valid_in, S_valid_in, W_valid_in, L_valid_in,
        output fifo_ready_N, fifo_ready_E, fifo_ready_S, fifo_ready_W, fifo_ready_L,
        output N_data_out, E_data_out, S_data_out, W_data_out, L_data_out,
        output N_valid_out, E_valid_out, S_valid_out, W_valid_out, L_valid_out,
        input  N_pressure_in, E_pressure_in, S_pressure_in, W_pressure_in, L_pressure_in
    );
endinterface

// File: rtl/router_switch.sv
// router_switch: 5-port XY-routed mesh switch with per-output round-robin arbitration.
// Single-flit packets, registered outputs, credit check against downstream occupancy.
module router_switch #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3,
    parameter int DATASIZE = 40,
    parameter logic [1:0] X_ID = 2'd0,
    parameter logic [1:0] Y_ID = 2'd0
) (
    input logic fifo_clk,
    input logic rst_n,
    router_switch_if.slave bus
);
    localparam int NP = 5;
    typedef enum logic [2:0] {P_N, P_E, P_S, P_W, P_L} port_t;

    logic [DATASIZE-1:0] din [NP];
    logic [DATASIZE-1:0] dout [NP];
    logic [WIDTH:0] prs [NP];
    logic [NP-1:0] vin, vout, rdy, room, hit;
    logic [NP-1:0] req [NP];
    logic [NP-1:0] gnt [NP];
    logic [2:0] sel [NP];
    logic [2:0] ptr [NP];

    function automatic logic [2:0] route(input logic [3:0] a);
        port_t p;
        p = (a[3:2] > X_ID) ? P_E :
            (a[3:2] < X_ID) ? P_W :
            (a[1:0] > Y_ID) ? P_N :
            (a[1:0] < Y_ID) ? P_S : P_L;
        return p;
    endfunction

    function automatic logic [2:0] wrap(input int v);
        return (v >= NP) ? 3'(v - NP) : 3'(v);
    endfunction

    assign din[0] = bus.N_data_in;
    assign din[1] = bus.E_data_in;
    assign din[2] = bus.S_data_in;
    assign din[3] = bus.W_data_in;
    assign din[4] = bus.L_data_in;
    assign vin = {bus.L_valid_in, bus.W_valid_in, bus.S_valid_in, bus.E_valid_in, bus.N_valid_in};
    assign prs[0] = bus.N_pressure_in;
    assign prs[1] = bus.E_pressure_in;
    assign prs[2] = bus.S_pressure_in;
    assign prs[3] = bus.W_pressure_in;
    assign prs[4] = bus.L_pressure_in;

    assign bus.fifo_ready_N = rdy[0];
    assign bus.fifo_ready_E = rdy[1];
    assign bus.fifo_ready_S = rdy[2];
    assign bus.fifo_ready_W = rdy[3];
    assign bus.fifo_ready_L = rdy[4];
    assign bus.N_valid_out = vout[0];
    assign bus.E_valid_out = vout[1];
    assign bus.S_valid_out = vout[2];
    assign bus.W_valid_out = vout[3];
    assign bus.L_valid_out = vout[4];
    assign bus.N_data_out = dout[0];
    assign bus.E_data_out = dout[1];
    assign bus.S_data_out = dout[2];
    assign bus.W_data_out = dout[3];
    assign bus.L_data_out = dout[4];

    // The flit currently on the link still lands downstream, so it counts against the space.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            room[o] = ({1'b0, prs[o]} + (WIDTH + 2)'(vout[o])) < (WIDTH + 2)'(DEPTH);
            for (int i = 0; i < NP; i++) req[o][i] = vin[i] && (route(din[i][3:0]) == 3'(o));
        end
    end

    // Scanning from farthest to nearest leaves the first requester at or after ptr selected.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            hit[o] = 1'b0;
            sel[o] = '0;
            for (int k = NP - 1; k >= 0; k--) begin
                if (room[o] && req[o][wrap(int'(ptr[o]) + k)]) begin
                    hit[o] = 1'b1;
                    sel[o] = wrap(int'(ptr[o]) + k);
                end
            end
            gnt[o] = hit[o] ? (NP'(1) << sel[o]) : '0;
        end
    end

    always_comb begin
        rdy = '0;
        for (int o = 0; o < NP; o++) rdy = rdy | gnt[o];
        rdy = rst_n ? rdy : '0;
    end

    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            vout <= '0;
            for (int o = 0; o < NP; o++) begin
                dout[o] <= '0;
                ptr[o] <= P_N;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                vout[o] <= hit[o];
                if (hit[o]) begin
                    dout[o] <= din[sel[o]];
                    ptr[o] <= wrap(int'(sel[o]) + 1);
                end
            end
        end
    end
endmodule

// File: doc/router_switch.md
ROUTER_SWITCH -- requirements
Module: router_switch

Interface
Parameters (name, default, meaning):
REQ-001 DEPTH, 8, capacity of each downstream input FIFO in flits.
REQ-002 WIDTH, 3, log2(DEPTH); pressure ports are WIDTH+1 bits.
REQ-003 DATASIZE, 40, flit width in bits.
REQ-004 X_ID, 0, 2-bit X coordinate of this router.
REQ-005 Y_ID, 0, 2-bit Y coordinate of this router.
Ports (name direction width meaning); P is each of N, E, S, W, L:
REQ-006 fifo_clk input 1 is the single clock; rst_n input 1 is the reset, asynchronous, active-low.
REQ-007 P_data_in input DATASIZE is the head flit of input FIFO P.
REQ-008 P_valid_in input 1 is high when input FIFO P is non-empty.
REQ-009 fifo_ready_P output 1 is the pop strobe to input FIFO P.
REQ-010 P_data_out output DATASIZE is the flit driven onto output link P.
REQ-011 P_valid_out output 1 is the write strobe to downstream FIFO P.
REQ-012 P_pressure_in input WIDTH+1 is the occupancy count of downstream FIFO P.

Function
REQ-013 Flits are single-flit packets: dst_x = data[3:2], dst_y = data[1:0].
REQ-014 XY route: dst_x > X_ID goes to E; dst_x < X_ID goes to W; otherwise dst_y > Y_ID goes to N; dst_y < Y_ID goes to S; otherwise L.
REQ-015 Each output has an independent round-robin arbiter over the 5 inputs requesting it, in order N, E, S, W, L.
REQ-016 Each arbiter's pointer resets to N and advances to the input after the granted one, only on a grant.
REQ-017 Output P is grantable in cycle t only if P_pressure_in + P_valid_out < DEPTH; this covers the flit already in flight.
REQ-018 fifo_ready_P is combinational and high in cycle t exactly when input P is granted; at most one grant per input per cycle.
REQ-019 A granted flit appears on X_data_out with X_valid_out=1 in cycle t+1 (registered, latency 1); each grant produces a one-cycle pulse.
REQ-020 X_data_out holds its last value when X_valid_out=0.
REQ-021 With no valid input, or with the output blocked, the arbiter pointer and all pop strobes stay unchanged or low.
REQ-022 Outputs with different targets proceed in the same cycle; up to 5 flits move per cycle.
REQ-023 A flit is never duplicated or dropped, and pressure never exceeds DEPTH.

Reset
REQ-024 With rst_n low: all P_valid_out=0, all P_data_out=0, all fifo_ready_P=0, all arbiter pointers=N, asynchronously.
REQ-025 Deassertion takes effect at the next fifo_clk edge; an in-flight flit is discarded, and its source FIFO has already popped it.

Verification
REQ-026 X_ID=1, Y_ID=1, N_valid_in=1, data[3:0]=4'b1001, pressure 0 -> fifo_ready_N=1 in cycle t; E_valid_out=1 with the same data in t+1.
REQ-027 All five inputs target L continuously, pressure 0 -> grants go N,E,S,W,L,N..., one per cycle, each pulse on L_valid_out one cycle later.
REQ-028 L_pressure_in=7 and L_valid_out=1 with a pending request -> no grant; the grant occurs when the sum falls below 8.
REQ-029 N routes to S, S routes to N, W routes to L at the same time -> three pops in one cycle, three outputs next cycle.
REQ-030 rst_n pulsed low mid-stream -> all outputs 0 immediately; after release, arbitration restarts from N.
